// File: rtl/periph_pkg.sv
// Shared definitions for the switch/LED bridge: register width, base address,
// register offsets and the address-decode helpers.
package periph_pkg;

   localparam int unsigned REG_W       = 10;
   localparam logic [31:0] PERIPH_BASE = 32'h0000_0400;

   localparam logic [3:0] OFF_SW    = 4'h0;
   localparam logic [3:0] OFF_LED   = 4'h4;
   localparam logic [3:0] OFF_CHG   = 4'h8;
   localparam logic [3:0] OFF_BLINK = 4'hC;

   // Word select within the 16-byte window, taken from address bits [3:2].
   typedef enum logic [1:0] {
      REG_SW    = OFF_SW[3:2],
      REG_LED   = OFF_LED[3:2],
      REG_CHG   = OFF_CHG[3:2],
      REG_BLINK = OFF_BLINK[3:2]
   } reg_sel_e;

   function automatic logic win_hit(input logic [27:0] addr_hi, input logic [27:0] base_hi);
      return addr_hi == base_hi;
   endfunction

   function automatic reg_sel_e reg_sel(input logic [1:0] word);
      return reg_sel_e'(word);
   endfunction

endpackage

// File: rtl/io_periph_bridge_if.sv
// Core data-bus port of the switch/LED bridge: byte address, write strobe,
// write data and combinational read data.
interface io_periph_bridge_if;

   logic [31:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output addr, we, wdata, input rdata);
   modport slave  (input addr, we, wdata, output rdata);

endinterface

// File: rtl/sw_debouncer.sv
// Two-flop synchroniser followed by a per-vector debounce filter; reports the
// accepted switch state and a one-cycle mask of bits that just changed.
module sw_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned WIDTH           = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_async,
   output logic [WIDTH-1:0] deb,
   output logic [WIDTH-1:0] chg_set
);

   localparam int unsigned      CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [WIDTH-1:0] deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The whole vector shares one candidate and one stability counter, so any
   // bit moving restarts the count for all of them.
   always_comb begin
      meta_d  = sw_async;
      sync_d  = meta_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      deb_d   = deb_q;
      chg_set = '0;
      if (sync_q != cand_q) begin
         cand_d = sync_q;
         cnt_d  = '0;
      end else if (cnt_q == CNT_MAX && cand_q != deb_q) begin
         deb_d   = cand_q;
         chg_set = cand_q ^ deb_q;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= '0;
         sync_q <= '0;
         cand_q <= '0;
         cnt_q  <= '0;
         deb_q  <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         deb_q  <= deb_d;
      end
   end

   assign deb = deb_q;

endmodule

// File: rtl/io_periph_bridge.sv
// Memory-mapped bridge between the core data bus and the board switches/LEDs:
// debounced switch register, sticky change flags, LED register and blink mask.
module io_periph_bridge
   import periph_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned BLINK_PERIOD    = 8,
   parameter logic [31:0] PERIPH_BASE     = periph_pkg::PERIPH_BASE
) (
   input  logic                clk,
   input  logic                reset,
   io_periph_bridge_if.slave   bus,
   input  logic [REG_W-1:0]    switches,
   output logic [REG_W-1:0]    leds
);

   localparam logic [23:0] BLINK_MAX = 24'(BLINK_PERIOD - 1);

   logic [REG_W-1:0] deb, chg_set;
   logic [REG_W-1:0] led_q, led_d;
   logic [REG_W-1:0] blink_q, blink_d;
   logic [REG_W-1:0] chg_q, chg_d;
   logic [23:0]      bcnt_q, bcnt_d;
   logic             phase_q, phase_d;
   logic             hit, wr;
   reg_sel_e         sel;
   logic             unused_bits;

   sw_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .WIDTH           (REG_W)
   ) u_sw_debouncer (
      .clk      (clk),
      .reset    (reset),
      .sw_async (switches),
      .deb      (deb),
      .chg_set  (chg_set)
   );

   assign hit         = win_hit(bus.addr[31:4], PERIPH_BASE[31:4]);
   assign sel         = reg_sel(bus.addr[3:2]);
   assign wr          = bus.we && hit;
   assign unused_bits = ^{bus.wdata[31:REG_W], bus.addr[1:0]};

   always_comb begin
      led_d   = led_q;
      blink_d = blink_q;
      chg_d   = chg_q;
      if (wr) begin
         case (sel)
            REG_LED:   led_d   = bus.wdata[REG_W-1:0];
            REG_CHG:   chg_d   = chg_q & ~bus.wdata[REG_W-1:0];
            REG_BLINK: blink_d = bus.wdata[REG_W-1:0];
            default:   ;
         endcase
      end
      // A fresh debounced change outranks a same-edge clear of that bit.
      chg_d   = chg_d | chg_set;
      bcnt_d  = (bcnt_q == BLINK_MAX) ? '0 : bcnt_q + 1'b1;
      phase_d = phase_q ^ (bcnt_q == BLINK_MAX);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_q   <= '0;
         blink_q <= '0;
         chg_q   <= '0;
         bcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         led_q   <= led_d;
         blink_q <= blink_d;
         chg_q   <= chg_d;
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
      end
   end

   always_comb begin
      bus.rdata = '0;
      if (hit) begin
         case (sel)
            REG_SW:    bus.rdata = {{(32-REG_W){1'b0}}, deb};
            REG_LED:   bus.rdata = {{(32-REG_W){1'b0}}, led_q};
            REG_CHG:   bus.rdata = {{(32-REG_W){1'b0}}, chg_q};
            default:   bus.rdata = {{(32-REG_W){1'b0}}, blink_q};
         endcase
      end
   end

   // Driven from flops only, so bus activity never glitches the LEDs.
   assign leds = led_q ^ (blink_q & {REG_W{phase_q}});

endmodule

// File: tb/tb_io_periph_bridge.sv
// Bench for io_periph_bridge: directed reset/debounce/race/blink sequences, a
// register-access vector table, and randomized traffic against a reference model.
module tb_io_periph_bridge;

   localparam int          D      = 4;
   localparam int          P      = 8;
   localparam logic [31:0] BASE   = 32'h0000_0400;
   localparam logic [31:0] A_SW   = BASE;
   localparam logic [31:0] A_LED  = BASE + 32'h4;
   localparam logic [31:0] A_CHG  = BASE + 32'h8;
   localparam logic [31:0] A_BLK  = BASE + 32'hC;
   localparam int          NV     = 12;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] switches;
   logic [9:0] leds;

   io_periph_bridge_if bus();

   io_periph_bridge #(
      .DEBOUNCE_CYCLES (D),
      .BLINK_PERIOD    (P),
      .PERIPH_BASE     (BASE)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .switches (switches),
      .leds     (leds)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [NV];

   // Reference model: a switch value is accepted once the last D+1 synchronised
   // samples (raw samples delayed by two edges) all agree on it.
   logic [9:0] m_hist [0:D+1];
   logic [9:0] m_deb, m_chg, m_led, m_blink;
   int         m_edges;

   task automatic model_reset();
      for (int i = 0; i <= D + 1; i++) m_hist[i] = '0;
      m_deb = '0; m_chg = '0; m_led = '0; m_blink = '0; m_edges = 0;
   endtask

   task automatic model_step();
      logic [9:0] v, setm;
      logic       stable;
      v = m_hist[1]; stable = 1'b1; setm = '0;
      for (int i = 2; i <= D + 1; i++) if (m_hist[i] != v) stable = 1'b0;
      if (stable && v != m_deb) begin
         setm  = v ^ m_deb;
         m_deb = v;
      end
      if (bus.we && bus.addr[31:4] == BASE[31:4]) begin
         case (bus.addr[3:2])
            2'd1:    m_led   = bus.wdata[9:0];
            2'd2:    m_chg   = m_chg & ~bus.wdata[9:0];
            2'd3:    m_blink = bus.wdata[9:0];
            default: ;
         endcase
      end
      m_chg = m_chg | setm;
      for (int i = D + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = switches;
      m_edges++;
   endtask

   function automatic logic [31:0] m_rd(input logic [31:0] a);
      if (a[31:4] != BASE[31:4]) return 32'd0;
      case (a[3:2])
         2'd0:    return {22'd0, m_deb};
         2'd1:    return {22'd0, m_led};
         2'd2:    return {22'd0, m_chg};
         default: return {22'd0, m_blink};
      endcase
   endfunction

   function automatic logic [9:0] m_leds();
      logic ph;
      ph = ((m_edges / P) % 2) == 1;
      return m_led ^ (m_blink & {10{ph}});
   endfunction

   task automatic tick();
      @(posedge clk);
      if (reset) model_step();
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.addr = a;
      bus.we   = 1'b0;
      #1;
      d = bus.rdata;
   endtask

   task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      check(name, d, exp);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.addr  = a;
      bus.wdata = d;
      bus.we    = 1'b1;
      tick();
      bus.we    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [9:0]  prev, exp_l;
      int          changes;

      tbl[0]  = '{BASE + 32'h4,  1'b1, 32'hFFFF_F0A5, 32'h0A5};
      tbl[1]  = '{BASE + 32'h10, 1'b1, 32'h0000_03FF, 32'h000};
      tbl[2]  = '{BASE + 32'h5,  1'b0, 32'h0,         32'h0A5};
      tbl[3]  = '{BASE + 32'h7,  1'b0, 32'h0,         32'h0A5};
      tbl[4]  = '{BASE + 32'h14, 1'b1, 32'h0,         32'h000};
      tbl[5]  = '{BASE + 32'h4,  1'b0, 32'h0,         32'h0A5};
      tbl[6]  = '{BASE + 32'hC,  1'b1, 32'h0000_0155, 32'h155};
      tbl[7]  = '{32'h0,         1'b1, 32'h0000_03FF, 32'h000};
      tbl[8]  = '{BASE + 32'hE,  1'b0, 32'h0,         32'h155};
      tbl[9]  = '{BASE,          1'b1, 32'h0000_03FF, 32'h004};
      tbl[10] = '{BASE + 32'h8,  1'b1, 32'h0000_03FF, 32'h000};
      tbl[11] = '{32'h8000_0404, 1'b0, 32'h0,         32'h000};

      // Reset held with all switches on.
      reset = 1'b0; model_reset();
      switches = 10'h3FF; bus.addr = '0; bus.we = 1'b0; bus.wdata = '0;
      repeat (3) tick();
      check("rst_leds", {22'd0, leds}, 32'd0);
      chk_rd("rst_sw", A_SW, 32'd0);
      chk_rd("rst_led", A_LED, 32'd0);
      chk_rd("rst_chg", A_CHG, 32'd0);
      chk_rd("rst_blink", A_BLK, 32'd0);
      reset = 1'b1;
      repeat (6) tick();
      chk_rd("post_rst_sw_e6", A_SW, 32'd0);
      chk_rd("post_rst_chg_e6", A_CHG, 32'd0);
      chk_rd("post_rst_blink_e6", A_BLK, 32'd0);
      check("post_rst_leds", {22'd0, leds}, 32'd0);
      tick();
      chk_rd("post_rst_sw_e7", A_SW, 32'h3FF);
      chk_rd("post_rst_chg_e7", A_CHG, 32'h3FF);

      // Fresh reset, then a two-cycle glitch.
      reset = 1'b0; model_reset(); switches = '0;
      tick(); tick();
      check("rst_clears_chg_leds", {22'd0, leds}, 32'd0);
      chk_rd("rst_clears_sw", A_SW, 32'd0);
      reset = 1'b1;
      repeat (3) tick();
      switches = 10'd1;
      repeat (2) tick();
      switches = 10'd0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_rd("glitch_sw", A_SW, 32'd0);
         chk_rd("glitch_chg", A_CHG, 32'd0);
      end

      // Debounce latency.
      switches = 10'd4;
      repeat (6) tick();
      chk_rd("deb_sw_e6", A_SW, 32'd0);
      tick();
      chk_rd("deb_sw_e7", A_SW, 32'd4);
      chk_rd("deb_chg_e7", A_CHG, 32'd4);

      // Clear racing a commit on a different bit.
      switches = 10'd6;
      repeat (6) tick();
      bus_write(A_CHG, 32'd4);
      chk_rd("race_chg", A_CHG, 32'd2);
      chk_rd("race_sw", A_SW, 32'd6);
      bus_write(A_CHG, 32'd2);
      chk_rd("race_chg_clr", A_CHG, 32'd0);

      // Clear racing a commit on the same bit.
      switches = 10'd4;
      repeat (6) tick();
      bus_write(A_CHG, 32'd2);
      chk_rd("same_bit_set_wins", A_CHG, 32'd2);
      chk_rd("same_bit_sw", A_SW, 32'd4);
      bus_write(A_CHG, 32'd2);
      chk_rd("same_bit_clr", A_CHG, 32'd0);

      // LED plus blink mask.
      bus_write(A_LED, 32'h00F);
      bus_write(A_BLK, 32'h003);
      chk_rd("blink_led_rd", A_LED, 32'h00F);
      prev = leds; changes = 0;
      for (int i = 0; i < 32; i++) begin
         tick();
         exp_l = (((m_edges / P) % 2) == 1) ? 10'h00C : 10'h00F;
         check("blink_leds", {22'd0, leds}, {22'd0, exp_l});
         if (leds != prev) changes++;
         prev = leds;
      end
      check("blink_toggles", changes, 32'd4);
      bus_write(A_BLK, 32'h0);
      check("blink_off_leds", {22'd0, leds}, 32'h00F);

      // Register access and decode table.
      for (int i = 0; i < NV; i++) begin
         if (tbl[i].we) bus_write(tbl[i].addr, tbl[i].wdata);
         rd(tbl[i].addr, d);
         check($sformatf("tbl%0d", i), d, tbl[i].exp);
      end
      bus_write(A_LED, 32'h0);
      bus_write(A_BLK, 32'h0);

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 9) == 0) switches = 10'($urandom);
         case ($urandom_range(0, 3))
            0, 1:    bus.addr = BASE + 32'($urandom_range(0, 15));
            2:       bus.addr = BASE + 32'h10 + 32'($urandom_range(0, 15));
            default: bus.addr = $urandom;
         endcase
         bus.wdata = $urandom;
         bus.we    = ($urandom_range(0, 3) == 0);
         #1;
         check("rnd_rdata", bus.rdata, m_rd(bus.addr));
         check("rnd_leds", {22'd0, leds}, {22'd0, m_leds()});
         tick();
      end
      bus.we = 1'b0;

      // Reset asserted between clock edges acts immediately.
      bus_write(A_LED, 32'h3FF);
      switches = 10'h2AA;
      repeat (8) tick();
      @(posedge clk);
      #3;
      reset = 1'b0; model_reset();
      #1;
      check("async_rst_leds", {22'd0, leds}, 32'd0);
      chk_rd("async_rst_led", A_LED, 32'd0);
      chk_rd("async_rst_sw", A_SW, 32'd0);
      chk_rd("async_rst_chg", A_CHG, 32'd0);
      tick();
      check("held_rst_leds", {22'd0, leds}, 32'd0);
      reset = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_periph_bridge.md
IO_PERIPH_BRIDGE -- requirements
Module: io_periph_bridge

Memory-mapped bridge between the ARM core data bus and the board switches/LEDs. It synchronises and debounces the switches, holds the LED state, and adds a hardware blink function.

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronised cycles required before a switch change is accepted (legal range 1 to 65535).
REQ-002 Parameter BLINK_PERIOD, default 8, is the number of clock cycles per blink phase (legal range 1 to 2^24).
REQ-003 Parameter PERIPH_BASE, default 32'h0000_0400, is the base address of the 16-byte register window.
REQ-004 Port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-006 Port addr, input, 32 bits, data-bus byte address from the core.
REQ-007 Port we, input, 1 bit, data-bus write enable.
REQ-008 Port wdata, input, 32 bits, data-bus write data.
REQ-009 Port rdata, output, 32 bits, combinational read data.
REQ-010 Port switches, input, 10 bits, raw asynchronous board switches.
REQ-011 Port leds, output, 10 bits, board LEDs.

Function
REQ-012 A window hit SHALL be defined as addr[31:4] == PERIPH_BASE[31:4]; addr[3:2] selects the register, and addr[1:0] is ignored.
REQ-013 The register map SHALL be: 0x0 SW (read-only, debounced switches); 0x4 LED (read/write); 0x8 CHG (sticky change flags, write-1-to-clear); 0xC BLINK (read/write blink mask).
REQ-014 Every register value SHALL occupy bits [9:0]; bits [31:10] SHALL read as 0 and SHALL be ignored on write.
REQ-015 A write SHALL take effect at the rising edge where we=1 and the window is hit; a write with no hit SHALL have no effect.
REQ-016 rdata SHALL be a combinational function of addr and register state, with zero cycles of read latency, and SHALL equal 0 when the window is not hit.
REQ-017 switches SHALL pass through a 2-flop synchroniser to produce sync.
REQ-018 Debounce rule, evaluated each cycle:
- If sync != cand, then cand <= sync and cnt <= 0.
- Else, if cnt == DEBOUNCE_CYCLES-1 and cand != deb, then deb <= cand and chg <= chg | (cand ^ deb).
- Otherwise, cnt increments and saturates at DEBOUNCE_CYCLES-1.
REQ-019 Latency: a switch change held stable SHALL appear in SW at the (DEBOUNCE_CYCLES+3)th rising edge after it; with the default parameters this is edge 7.
REQ-020 A glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL NOT change deb or chg.
REQ-021 A CHG write SHALL clear every bit written as 1; if a clear and a new change hit the same bit on the same edge, the set SHALL win.
REQ-022 The blink counter SHALL count 0..BLINK_PERIOD-1 and wrap to 0; phase SHALL toggle on each wrap.
REQ-023 leds SHALL equal led_reg XOR (blink_mask AND {10{phase}}) and SHALL be registered-state-only, with no combinational path from the bus.
REQ-024 Writing LED SHALL load led_reg without resetting the blink counter or phase; writing BLINK SHALL likewise leave counter and phase untouched.

Reset
REQ-025 While reset=0, the following SHALL all be 0, asynchronously:
- both synchroniser flops, cand, cnt, deb and chg;
- led_reg, blink_mask, the blink counter and phase.
Consequently leds=0, and rdata=0 for every address.
REQ-026 Debounce and blink activity SHALL begin on the first rising edge after reset deasserts.
REQ-027 Reset asserted mid-debounce or mid-blink SHALL abandon the operation; no partial update SHALL survive.

Structure
REQ-028 The register offsets (SW, LED, CHG, BLINK), the register width (10) and PERIPH_BASE SHALL live in the shared package periph_pkg.
REQ-029 The synchroniser and debounce logic SHALL be one sub-module, sw_debouncer, parameterised by DEBOUNCE_CYCLES and WIDTH.
REQ-030 The blink timer and register file SHALL be implemented inline.

Verification
REQ-031 Reset: hold reset=0 with switches=10'h3FF, then release -> leds=0; SW, CHG and BLINK read 0 until debounce completes.
REQ-032 Debounce: after reset, switches 0 -> 10'd4 held -> SW=4 and CHG=4 at edge 7; SW=0 at edge 6.
REQ-033 Glitch: switches=10'd1 for 2 cycles, then 0 -> SW and CHG remain 0 for 20 cycles.
REQ-034 Write-1-to-clear race: CHG=4; write CHG=4 on the same edge that switch bit 1 is committed -> CHG=2; then write CHG=2 -> CHG=0.
REQ-035 LED/blink: write LED=10'h00F, then BLINK=10'h003 -> leds alternates 10'h00F and 10'h00C every 8 cycles; a read at 0x4 returns 10'h00F.
REQ-036 Decode: write to PERIPH_BASE+0x10 -> no register changes and rdata=0; a read at PERIPH_BASE+0x5 returns the LED value.
